// File: rtl/store_writer_if.sv
// rtl/store_writer_if.sv - ROB store-commit and RAM write-bus signals for store_writer
interface store_writer_if #(
    parameter int XLEN     = 32,
    parameter int OP_WIDTH = 3
);
    logic                st_enable;
    logic [OP_WIDTH-1:0] st_op;
    logic [XLEN-1:0]     st_addr;
    logic [XLEN-1:0]     st_val;
    logic                ram_gnt;
    logic                mem_busy;
    logic                ram_req;
    logic                ram_wr;
    logic [XLEN-1:0]     ram_a;
    logic [7:0]          ram_dout;
    logic                st_done;

    modport master (
        output st_enable, st_op, st_addr, st_val, ram_gnt,
        input  mem_busy, ram_req, ram_wr, ram_a, ram_dout, st_done
    );

    modport slave (
        input  st_enable, st_op, st_addr, st_val, ram_gnt,
        output mem_busy, ram_req, ram_wr, ram_a, ram_dout, st_done
    );
endinterface

// File: rtl/store_writer.sv
// rtl/store_writer.sv - byte-serial little-endian writer for committed SB/SH/SW stores
module store_writer #(
    parameter int                     XLEN     = 32,
    parameter int                     OP_WIDTH = 3,
    parameter logic [OP_WIDTH-1:0]    OP_SB    = 3'd0,
    parameter logic [OP_WIDTH-1:0]    OP_SH    = 3'd1,
    parameter logic [OP_WIDTH-1:0]    OP_SW    = 3'd2,
    parameter logic [XLEN-1:0]        IO_ADDR  = 32'h0003_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          io_buffer_full,
    store_writer_if.slave sw
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] val_q, val_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0]      last_q, last_d;
    logic            op_valid;
    logic [1:0]      op_last;
    logic            ok;

    always_comb begin
        op_valid = 1'b1;
        op_last  = 2'd0;
        case (sw.st_op)
            OP_SB:   op_last = 2'd0;
            OP_SH:   op_last = 2'd1;
            OP_SW:   op_last = 2'd3;
            default: op_valid = 1'b0;
        endcase
    end

    // A byte goes out only when the bus is ours and, for the MMIO port, the sink has room.
    assign ok = (state_q == S_WRITE) && rdy && sw.ram_gnt &&
                !((addr_q == IO_ADDR) && io_buffer_full);

    assign sw.ram_req  = (state_q == S_WRITE);
    assign sw.ram_wr   = ok;
    assign sw.ram_a    = ok ? (addr_q + XLEN'(cnt_q)) : '0;
    assign sw.ram_dout = ok ? val_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign sw.st_done  = ok && (cnt_q == last_q);
    // Enable counts as busy already so the ROB cannot commit again on the following cycle.
    assign sw.mem_busy = sw.st_enable || (state_q == S_WRITE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (sw.st_enable && op_valid) begin
                        state_d = S_WRITE;
                        addr_d  = sw.st_addr;
                        val_d   = sw.st_val;
                        cnt_d   = 2'd0;
                        last_d  = op_last;
                    end
                end
                S_WRITE: begin
                    if (ok) begin
                        if (cnt_q == last_q) begin
                            state_d = S_IDLE;
                            cnt_d   = 2'd0;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            val_q   <= '0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
endmodule
